// File: rtl/hdmi_pattern_gen_pkg.sv
// Shared encodings for the HDMI test-pattern source: modes, colours, sequencer states.
package hdmi_pattern_pkg;

   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_CHECK = 2'd1;
   localparam logic [1:0] MODE_RAMP  = 2'd2;
   localparam logic [1:0] MODE_BOX   = 2'd3;

   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] BLUE  = 24'h0000FF;

   // Left-to-right bar order; each channel is fully on or fully off.
   localparam logic [23:0] BAR_COLORS [0:7] = '{
      WHITE,        // white
      24'hFFFF00,   // yellow
      24'h00FFFF,   // cyan
      24'h00FF00,   // green
      24'hFF00FF,   // magenta
      24'hFF0000,   // red
      BLUE,         // blue
      BLACK         // black
   };

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } seq_state_t;

endpackage

// File: rtl/hdmi_bounce_ctr.sv
// Position that ping-pongs between 0 and LIMIT one step per enabled cycle.
// pos already includes the step taken this cycle, so same-cycle consumers see the new value.
module hdmi_bounce_ctr #(
   parameter int W     = 10,
   parameter int LIMIT = 576
) (
   input  logic         clkx1,
   input  logic         rstin,
   input  logic         step_en,
   output logic [W-1:0] pos
);

   localparam logic [W-1:0] LIM = W'(LIMIT);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] r_pos;
   logic         r_dir;
   logic [W-1:0] w_pos_nxt;
   logic         w_dir_nxt;

   // At either end the direction flips and the step goes the new way in the same update.
   always_comb begin
      w_pos_nxt = r_pos;
      w_dir_nxt = r_dir;
      if (step_en) begin
         if (!r_dir) begin
            if (r_pos == LIM) begin
               w_dir_nxt = 1'b1;
               w_pos_nxt = r_pos - ONE;
            end else begin
               w_pos_nxt = r_pos + ONE;
            end
         end else begin
            if (r_pos == '0) begin
               w_dir_nxt = 1'b0;
               w_pos_nxt = r_pos + ONE;
            end else begin
               w_pos_nxt = r_pos - ONE;
            end
         end
      end
   end

   always_ff @(posedge clkx1) begin
      if (rstin) begin
         r_pos <= '0;
         r_dir <= 1'b0;
      end else begin
         r_pos <= w_pos_nxt;
         r_dir <= w_dir_nxt;
      end
   end

   assign pos = w_pos_nxt;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern source: tracks the active-pixel position and renders one of four patterns.
// rgb_data is registered one cycle after the pixel_de sample; there is no backpressure.
module hdmi_pattern_gen
   import hdmi_pattern_pkg::*;
#(
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int FRAMES_PER_MODE = 120,
   parameter int BOX             = 64
) (
   input  logic        clkx1,
   input  logic        rstin,
   input  logic        pixel_de,
   input  logic        pixel_start_flag,
   input  logic        auto_en,
   input  logic [1:0]  mode_sel,
   output logic [23:0] rgb_data,
   output logic [1:0]  cur_mode
);

   localparam int XW  = $clog2(H_ACTIVE);
   localparam int YW  = $clog2(V_ACTIVE);
   localparam int FCW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

   localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
   localparam logic [XW-1:0]  BAR_W   = XW'(H_ACTIVE / 8);
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_MODE - 1);

   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   seq_state_t     r_state;
   seq_state_t     w_state_nxt;
   logic [1:0]     r_mode;
   logic [1:0]     w_mode_nxt;
   logic [FCW-1:0] r_fc;
   logic [FCW-1:0] w_fc_nxt;
   logic [23:0]    r_rgb;
   logic [23:0]    w_rgb;
   logic [XW-1:0]  w_bx;
   logic [YW-1:0]  w_by;
   logic [XW-1:0]  w_rx;
   logic [YW-1:0]  w_ry;
   logic [2:0]     w_bar_idx;
   logic           w_check;
   logic [7:0]     w_ramp;
   logic           w_inside;

   // Position counters: a start flag with a pixel renders (0,0) and leaves x at 1.
   always_ff @(posedge clkx1) begin
      if (rstin) begin
         r_x <= '0;
         r_y <= '0;
      end else if (pixel_start_flag) begin
         r_x <= pixel_de ? XW'(1) : '0;
         r_y <= '0;
      end else if (pixel_de) begin
         if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y != Y_LAST) begin
               r_y <= r_y + YW'(1);
            end
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   // Mode sequencer: state register
   always_ff @(posedge clkx1) begin
      if (rstin) begin
         r_state <= ST_MANUAL;
         r_mode  <= MODE_BARS;
         r_fc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_fc    <= w_fc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (pixel_start_flag) begin
         w_state_nxt = auto_en ? ST_AUTO : ST_MANUAL;
      end
   end

   // The state held during the ending frame decides what this boundary does.
   always_comb begin
      w_mode_nxt = r_mode;
      w_fc_nxt   = r_fc;
      if (pixel_start_flag) begin
         if (r_state == ST_AUTO) begin
            if (r_fc == FC_LAST) begin
               w_fc_nxt   = '0;
               w_mode_nxt = r_mode + 2'd1;
            end else begin
               w_fc_nxt = r_fc + FCW'(1);
            end
         end else begin
            w_mode_nxt = mode_sel;
            w_fc_nxt   = '0;
         end
      end
   end

   hdmi_bounce_ctr #(
      .W     (XW),
      .LIMIT (H_ACTIVE - BOX)
   ) u_box_x (
      .clkx1   (clkx1),
      .rstin   (rstin),
      .step_en (pixel_start_flag),
      .pos     (w_bx)
   );

   hdmi_bounce_ctr #(
      .W     (YW),
      .LIMIT (V_ACTIVE - BOX)
   ) u_box_y (
      .clkx1   (clkx1),
      .rstin   (rstin),
      .step_en (pixel_start_flag),
      .pos     (w_by)
   );

   // Render coordinates and frame values already reflect a same-cycle start flag.
   assign w_rx      = pixel_start_flag ? '0 : r_x;
   assign w_ry      = pixel_start_flag ? '0 : r_y;
   assign w_bar_idx = 3'(w_rx / BAR_W);
   assign w_check   = 1'(w_rx >> 5) ^ 1'(w_ry >> 5);
   assign w_ramp    = 8'(32'(w_rx) >> 2);
   assign w_inside  = (32'(w_rx) >= 32'(w_bx)) && (32'(w_rx) < 32'(w_bx) + 32'(BOX)) &&
                      (32'(w_ry) >= 32'(w_by)) && (32'(w_ry) < 32'(w_by) + 32'(BOX));

   always_comb begin
      w_rgb = BLACK;
      case (w_mode_nxt)
         MODE_BARS:  w_rgb = BAR_COLORS[w_bar_idx];
         MODE_CHECK: w_rgb = w_check ? WHITE : BLACK;
         MODE_RAMP:  w_rgb = {w_ramp, w_ramp, w_ramp};
         MODE_BOX:   w_rgb = w_inside ? WHITE : BLUE;
         default:    w_rgb = BLACK;
      endcase
   end

   always_ff @(posedge clkx1) begin
      if (rstin) begin
         r_rgb <= BLACK;
      end else if (pixel_de) begin
         r_rgb <= w_rgb;
      end else begin
         r_rgb <= BLACK;
      end
   end

   assign rgb_data = r_rgb;
   assign cur_mode = r_mode;

endmodule
